piso_shift_ctrl: RTL and testbench
==================================

// Module: piso_shift_ctrl
// PURPOSE
//  Sequencer for the serial shift-register datapath: accepts parallel words over a
//  valid/ready handshake, serializes each word onto a 1-bit line one bit per clock,
//  marks first/last bit of every frame and inserts a programmable idle gap between
//  frames. Sits between a parallel producer and the serial shift chain / pad.
// PARAMETERS
//  WIDTH      8  bits per frame (>=2)
//  GAP        2  idle cycles inserted after each frame (0 allowed)
//  MSB_FIRST  1  1: bit WIDTH-1 shifted out first; 0: bit 0 first
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst          in   1      reset, asynchronous, active-low
//  in_data      in   WIDTH  parallel word to serialize
//  in_valid     in   1      producer has a word on in_data
//  in_ready     out  1      controller can accept a word this cycle
//  hold         in   1      stall: freeze shifting while high
//  ser_out      out  1      serial data bit
//  ser_valid    out  1      ser_out carries a valid bit this cycle
//  frame_start  out  1      pulse with first bit of frame
//  frame_done   out  1      pulse with last bit of frame
//  busy         out  1      high in SHIFT or GAP
//  bit_cnt      out  CW     bits already sent in current frame, CW=$clog2(WIDTH+1)
// BEHAVIOUR
//  - All outputs registered. rst low: state IDLE, shift reg, counters and every
//    output = 0 (incl. in_ready); partial frame discarded, no frame_done emitted.
//  - in_ready = 1 only in IDLE, from first rising edge after rst release.
//  - FSM IDLE -> SHIFT on in_valid & in_ready (word captured at that edge).
//    SHIFT -> GAP after WIDTH-th bit (GAP>0), else SHIFT -> IDLE. GAP -> IDLE after
//    GAP cycles. hold has no effect in IDLE or GAP (gap counts regardless).
//  - Latency: word accepted at edge k -> first bit on ser_out with ser_valid=1 in
//    cycle after edge k. Frame occupies WIDTH cycles with hold=0. Max throughput one
//    word per WIDTH+GAP+1 cycles (in_ready low during SHIFT and GAP).
//  - SHIFT, hold=0: ser_valid=1, ser_out = next bit in MSB_FIRST order, bit_cnt
//    increments after each bit (reads 0 with first bit, WIDTH-1 with last).
//  - SHIFT, hold=1: ser_valid=0, ser_out, bit_cnt and shift reg frozen; the held bit
//    is re-presented with ser_valid=1 when hold drops; no bit lost or duplicated.
//  - frame_start=1 only in the cycle bit 0 of the frame is valid; frame_done=1 only in
//    the cycle the last bit is valid; both suppressed while hold=1.
//  - IDLE/GAP: ser_out=0, ser_valid=0, bit_cnt=0. in_valid ignored outside IDLE;
//    in_data need not be stable after acceptance.
//  - hold asserted in same cycle as acceptance: word still captured; first bit
//    delayed until hold low.
// TESTING
//  1 Reset: rst=0 mid-frame with in_valid=1 -> all outputs 0; after release in_ready=1
//    on next edge, no frame_done ever seen for aborted word.
//  2 WIDTH=8, MSB_FIRST=1, in_data=8'hA5, hold=0 -> ser_out 1,0,1,0,0,1,0,1 on 8
//    consecutive ser_valid cycles; frame_start on bit 1, frame_done on bit 8.
//  3 MSB_FIRST=0, in_data=8'h01 -> ser_out 1 then seven 0s; bit_cnt 0..7.
//  4 Back-to-back 8'hFF, 8'h00 with in_valid held high, GAP=2 -> 2 idle cycles
//    (busy=1, ser_valid=0) then in_ready=1 one cycle, second frame starts next cycle.
//  5 hold=1 for 3 cycles after bit 3 of 8'hC3 -> ser_valid low 3 cycles, bit 4 then
//    resumes; full sequence 1,1,0,0,0,0,1,1 intact, frame length 11 cycles.
//  6 GAP=0, two words -> second accepted in IDLE cycle right after frame_done; hold
//    asserted on accept cycle delays first bit, frame_start follows hold release.

Source files
------------

// File: rtl/piso_shift_ctrl_if.sv
// piso_shift_ctrl_if: parallel-in handshake plus serial-out bundle between producer and piso_shift_ctrl
interface piso_shift_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic hold;
    logic ser_out;
    logic ser_valid;
    logic frame_start;
    logic frame_done;
    logic busy;
    logic [CW-1:0] bit_cnt;
    modport master (
        output in_data, in_valid, hold,
        input in_ready, ser_out, ser_valid, frame_start, frame_done, busy, bit_cnt
    );
    modport slave (
        input in_data, in_valid, hold,
        output in_ready, ser_out, ser_valid, frame_start, frame_done, busy, bit_cnt
    );
endinterface

// File: rtl/piso_shift_ctrl.sv
// piso_shift_ctrl: serializes accepted words one bit per clock with frame markers, hold stall and idle gap
module piso_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int GAP = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic clk,
    input logic rst,
    piso_shift_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
    localparam int GL = GAP > 0 ? GAP - 1 : 0;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
    state_t r_state, w_state;
    logic [WIDTH-1:0] r_sr, w_sr, w_src, w_shifted;
    logic [CW-1:0] r_sent, w_sent, w_cur, r_cnt, w_cnt;
    logic [GW-1:0] r_gap, w_gap;
    logic r_ready, r_out, r_valid, r_start, r_done, r_busy;
    logic w_acc, w_more, w_pres, w_first, w_out;
    // r_sent counts bits already presented; a frame is complete once it reaches WIDTH
    always_comb begin
        w_acc = r_state == S_IDLE && bus.in_valid && r_ready;
        w_src = w_acc ? bus.in_data : r_sr;
        w_cur = w_acc ? '0 : r_sent;
        w_more = w_acc || (r_state == S_SHIFT && r_sent != CW'(WIDTH));
        w_pres = w_more && !bus.hold;
        w_first = MSB_FIRST ? w_src[WIDTH-1] : w_src[0];
        w_shifted = MSB_FIRST ? {w_src[WIDTH-2:0], 1'b0} : {1'b0, w_src[WIDTH-1:1]};
        w_sr = w_pres ? w_shifted : w_src;
        w_sent = w_pres ? w_cur + CW'(1) : w_cur;
        w_out = w_pres ? w_first : (w_more ? r_out : 1'b0);
        w_cnt = w_pres ? w_cur : (w_more ? r_cnt : '0);
        w_gap = r_state == S_GAP ? r_gap + GW'(1) : '0;
        w_state = r_state == S_IDLE ? (w_acc ? S_SHIFT : S_IDLE) :
                  r_state == S_SHIFT ? (r_sent == CW'(WIDTH) ? (GAP > 0 ? S_GAP : S_IDLE) : S_SHIFT) :
                  (r_gap == GW'(GL) ? S_IDLE : S_GAP);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sr <= '0;
            r_sent <= '0;
            r_gap <= '0;
            r_ready <= 1'b0;
            r_busy <= 1'b0;
            r_out <= 1'b0;
            r_valid <= 1'b0;
            r_start <= 1'b0;
            r_done <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_state <= w_state;
            r_sr <= w_sr;
            r_sent <= w_sent;
            r_gap <= w_gap;
            r_ready <= w_state == S_IDLE;
            r_busy <= w_state != S_IDLE;
            r_out <= w_out;
            r_valid <= w_pres;
            r_start <= w_pres && w_cur == '0;
            r_done <= w_pres && w_cur == CW'(WIDTH - 1);
            r_cnt <= w_cnt;
        end
    end
    assign bus.in_ready = r_ready;
    assign bus.busy = r_busy;
    assign bus.ser_out = r_out;
    assign bus.ser_valid = r_valid;
    assign bus.frame_start = r_start;
    assign bus.frame_done = r_done;
    assign bus.bit_cnt = r_cnt;
endmodule

// File: tb/tb_piso_shift_ctrl.sv
// tb_piso_shift_ctrl: directed checks on an MSB-first GAP=2 instance and an LSB-first GAP=0 instance
module tb_piso_shift_ctrl;
    logic clk;
    logic rst;
    int n_vec;
    int n_err;
    piso_shift_ctrl_if #(.WIDTH(8)) ia ();
    piso_shift_ctrl_if #(.WIDTH(8)) ib ();
    piso_shift_ctrl #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    piso_shift_ctrl #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    // {ser_valid, ser_out, frame_start, frame_done, busy, in_ready, bit_cnt}
    logic [9:0] oa, ob;
    assign oa = {ia.ser_valid, ia.ser_out, ia.frame_start, ia.frame_done, ia.busy, ia.in_ready, ia.bit_cnt};
    assign ob = {ib.ser_valid, ib.ser_out, ib.frame_start, ib.frame_done, ib.busy, ib.in_ready, ib.bit_cnt};
    localparam logic [9:0] E_ZERO = 10'b00_0000_0000;
    localparam logic [9:0] E_IDLE = 10'b00_0001_0000;
    localparam logic [9:0] E_GAP = 10'b00_0010_0000;
    always #5 clk = ~clk;
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        #3;
        n_vec++; if (oa !== E_ZERO) begin n_err++; $display("FAIL reset_a: got %b want %b", oa, E_ZERO); end
        n_vec++; if (ob !== E_ZERO) begin n_err++; $display("FAIL reset_b: got %b want %b", ob, E_ZERO); end
        step();
        step();
        n_vec++; if (oa !== E_ZERO) begin n_err++; $display("FAIL reset_held: got %b want %b", oa, E_ZERO); end
        rst = 1'b1;
        step();
        n_vec++; if (oa !== E_IDLE) begin n_err++; $display("FAIL release_a: got %b want %b", oa, E_IDLE); end
        n_vec++; if (ob !== E_IDLE) begin n_err++; $display("FAIL release_b: got %b want %b", ob, E_IDLE); end
        ia.in_data = 8'hA5;
        ia.in_valid = 1'b1;
        step();
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if (oa !== E_ZERO) begin n_err++; $display("FAIL async_abort: got %b want %b", oa, E_ZERO); end
        step();
        n_vec++; if (oa !== E_ZERO) begin n_err++; $display("FAIL abort_held: got %b want %b", oa, E_ZERO); end
        rst = 1'b1;
        ia.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (oa !== E_IDLE) begin n_err++; $display("FAIL post_abort%0d: got %b want %b", i, oa, E_IDLE); end
        end
    endtask
    task automatic test_msb_first;
        logic [7:0] w;
        logic [9:0] e;
        w = 8'hA5;
        ia.in_data = w;
        ia.in_valid = 1'b1;
        step();
        ia.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = {1'b1, w[7-i], i == 0, i == 7, 1'b1, 1'b0, 4'(i)};
            n_vec++; if (oa !== e) begin n_err++; $display("FAIL msb_bit%0d: got %b want %b", i, oa, e); end
            step();
        end
        n_vec++; if (oa !== E_GAP) begin n_err++; $display("FAIL msb_gap: got %b want %b", oa, E_GAP); end
        step();
        step();
        n_vec++; if (oa !== E_IDLE) begin n_err++; $display("FAIL msb_idle: got %b want %b", oa, E_IDLE); end
    endtask
    task automatic test_lsb_first;
        logic [7:0] w;
        logic [9:0] e;
        w = 8'h01;
        ib.in_data = w;
        ib.in_valid = 1'b1;
        step();
        ib.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = {1'b1, w[i], i == 0, i == 7, 1'b1, 1'b0, 4'(i)};
            n_vec++; if (ob !== e) begin n_err++; $display("FAIL lsb_bit%0d: got %b want %b", i, ob, e); end
            step();
        end
        n_vec++; if (ob !== E_IDLE) begin n_err++; $display("FAIL lsb_idle: got %b want %b", ob, E_IDLE); end
    endtask
    task automatic test_back_to_back;
        logic [7:0] w;
        logic [9:0] e;
        w = 8'hFF;
        ia.in_data = w;
        ia.in_valid = 1'b1;
        step();
        ia.in_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            e = {1'b1, w[7-i], i == 0, i == 7, 1'b1, 1'b0, 4'(i)};
            n_vec++; if (oa !== e) begin n_err++; $display("FAIL b2b_ff_bit%0d: got %b want %b", i, oa, e); end
            step();
        end
        for (int g = 0; g < 2; g++) begin
            n_vec++; if (oa !== E_GAP) begin n_err++; $display("FAIL b2b_gap%0d: got %b want %b", g, oa, E_GAP); end
            step();
        end
        n_vec++; if (oa !== E_IDLE) begin n_err++; $display("FAIL b2b_ready: got %b want %b", oa, E_IDLE); end
        step();
        ia.in_valid = 1'b0;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            e = {1'b1, w[7-i], i == 0, i == 7, 1'b1, 1'b0, 4'(i)};
            n_vec++; if (oa !== e) begin n_err++; $display("FAIL b2b_00_bit%0d: got %b want %b", i, oa, e); end
            step();
        end
        step();
        step();
        n_vec++; if (oa !== E_IDLE) begin n_err++; $display("FAIL b2b_idle: got %b want %b", oa, E_IDLE); end
    endtask
    task automatic test_hold;
        logic [7:0] w;
        logic [9:0] e;
        int k;
        w = 8'hC3;
        k = 0;
        ia.in_data = w;
        ia.in_valid = 1'b1;
        step();
        ia.in_valid = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (c >= 3 && c <= 5) e = {1'b0, w[5], 1'b0, 1'b0, 1'b1, 1'b0, 4'd2};
            else begin
                e = {1'b1, w[7-k], k == 0, k == 7, 1'b1, 1'b0, 4'(k)};
                k++;
            end
            n_vec++; if (oa !== e) begin n_err++; $display("FAIL hold_cyc%0d: got %b want %b", c, oa, e); end
            ia.hold = c >= 2 && c <= 4;
            step();
        end
        n_vec++; if (oa !== E_GAP) begin n_err++; $display("FAIL hold_gap0: got %b want %b", oa, E_GAP); end
        ia.hold = 1'b1;
        step();
        n_vec++; if (oa !== E_GAP) begin n_err++; $display("FAIL hold_gap1: got %b want %b", oa, E_GAP); end
        step();
        n_vec++; if (oa !== E_IDLE) begin n_err++; $display("FAIL hold_gap_idle: got %b want %b", oa, E_IDLE); end
        ia.hold = 1'b0;
    endtask
    task automatic test_gap0_hold_accept;
        logic [7:0] w;
        logic [9:0] e;
        w = 8'h5A;
        ib.in_data = w;
        ib.in_valid = 1'b1;
        step();
        ib.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = {1'b1, w[i], i == 0, i == 7, 1'b1, 1'b0, 4'(i)};
            n_vec++; if (ob !== e) begin n_err++; $display("FAIL g0_w1_bit%0d: got %b want %b", i, ob, e); end
            step();
        end
        n_vec++; if (ob !== E_IDLE) begin n_err++; $display("FAIL g0_ready: got %b want %b", ob, E_IDLE); end
        w = 8'h81;
        ib.in_data = w;
        ib.in_valid = 1'b1;
        ib.hold = 1'b1;
        step();
        ib.in_valid = 1'b0;
        ib.in_data = 8'h00;
        n_vec++; if (ob !== E_GAP) begin n_err++; $display("FAIL g0_hold0: got %b want %b", ob, E_GAP); end
        step();
        n_vec++; if (ob !== E_GAP) begin n_err++; $display("FAIL g0_hold1: got %b want %b", ob, E_GAP); end
        ib.hold = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            e = {1'b1, w[i], i == 0, i == 7, 1'b1, 1'b0, 4'(i)};
            n_vec++; if (ob !== e) begin n_err++; $display("FAIL g0_w2_bit%0d: got %b want %b", i, ob, e); end
            step();
        end
        n_vec++; if (ob !== E_IDLE) begin n_err++; $display("FAIL g0_idle: got %b want %b", ob, E_IDLE); end
    endtask
    initial begin
        n_vec = 0;
        n_err = 0;
        clk = 1'b0;
        rst = 1'b0;
        ia.in_data = '0;
        ia.in_valid = 1'b0;
        ia.hold = 1'b0;
        ib.in_data = '0;
        ib.in_valid = 1'b0;
        ib.hold = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_hold();
        test_gap0_hold_accept();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
